recv_frame_parser: RTL and testbench

Read-side consumer of the receive async FIFO in the slave board datapath. Pops 32-bit words from the FIFO read port (1-cycle read latency, no output register), delimits frames by sync header, forwards payload words as a valid/ready stream with first/last markers, and checks a trailer checksum. Runs entirely in the FIFO read-clock domain.

---
 rtl/recv_frame_pkg.sv | 25 ++
 rtl/recv_skid_buf.sv | 77 +++++++
 rtl/recv_frame_parser.sv | 192 +++++++++++++++++++
 tb/tb_recv_frame_parser.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/recv_frame_pkg.sv
// Shared definitions for the receive frame parser: sync value, header field
// positions, FSM state encoding and a saturating counter helper.
package recv_frame_pkg;

    localparam logic [15:0] SYNC_WORD_DEF = 16'hA55A;

    // Header word layout
    localparam int unsigned HDR_SYNC_HI = 31;
    localparam int unsigned HDR_SYNC_LO = 16;
    localparam int unsigned HDR_TYPE_HI = 15;
    localparam int unsigned HDR_TYPE_LO = 8;
    localparam int unsigned HDR_LEN_HI  = 7;
    localparam int unsigned HDR_LEN_LO  = 0;

    typedef enum logic [1:0] {
        ST_HUNT    = 2'd0,
        ST_PAYLOAD = 2'd1,
        ST_TRAILER = 2'd2
    } state_e;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == '1) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/recv_skid_buf.sv
// Two-entry valid/ready buffer. The head entry drives the output directly, so
// the output holds still while valid is high and ready is low. The writer is
// responsible for never pushing into a full buffer; occupancy is exposed for it.
module recv_skid_buf
    import recv_frame_pkg::*;
#(
    parameter int unsigned W = 34
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         in_valid_i,
    input  logic [W-1:0] in_data_i,
    output logic         out_valid_o,
    input  logic         out_ready_i,
    output logic [W-1:0] out_data_o,
    output logic [1:0]   occ_o
);

    logic [W-1:0] head_q, head_d;
    logic [W-1:0] tail_q, tail_d;
    logic [1:0]   cnt_q, cnt_d;
    logic         pop;

    assign pop         = (cnt_q != 2'd0) && out_ready_i;
    assign out_valid_o = (cnt_q != 2'd0);
    assign out_data_o  = head_q;
    assign occ_o       = cnt_q;

    // Next-state for head/tail entries and occupancy
    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        cnt_d  = cnt_q;
        case (cnt_q)
            2'd0: begin
                if (in_valid_i) begin
                    head_d = in_data_i;
                    cnt_d  = 2'd1;
                end
            end
            2'd1: begin
                if (in_valid_i && pop) begin
                    head_d = in_data_i;
                end else if (in_valid_i) begin
                    tail_d = in_data_i;
                    cnt_d  = 2'd2;
                end else if (pop) begin
                    cnt_d = 2'd0;
                end
            end
            default: begin
                if (pop) begin
                    head_d = tail_q;
                    if (in_valid_i) begin
                        tail_d = in_data_i;
                    end else begin
                        cnt_d = 2'd1;
                    end
                end
            end
        endcase
    end

    // Buffer storage registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            head_q <= '0;
            tail_q <= '0;
            cnt_q  <= '0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: rtl/recv_frame_parser.sv
// Receive frame parser: pops words from the async FIFO read port, hunts for
// the sync header, forwards payload with first/last markers through a small
// output buffer and verifies the trailer checksum.
module recv_frame_parser
    import recv_frame_pkg::*;
#(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned MAX_LEN   = 255,
    parameter logic [15:0] SYNC_WORD = SYNC_WORD_DEF
) (
    input  logic              rd_clk,
    input  logic              rd_rst_n,
    output logic              fifo_rd_en,
    input  logic [DATA_W-1:0] fifo_rd_data,
    input  logic              fifo_rd_empty,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_first,
    output logic              m_last,
    output logic [7:0]        m_type,
    output logic              frame_done,
    output logic              frame_err,
    output logic [15:0]       ok_cnt,
    output logic [15:0]       err_cnt,
    output logic [15:0]       drop_cnt
);

    state_e             state_q, state_d;
    logic               run_q;
    logic               inflight_q;
    logic [DATA_W-1:0]  sum_q, sum_d;
    logic [7:0]         cnt_q, cnt_d;
    logic [7:0]         type_q, type_d;
    logic               first_q, first_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic [15:0]        ok_cnt_q, err_cnt_q, drop_cnt_q;
    logic               ok_inc, err_inc, drop_inc;

    logic               push;
    logic               push_first, push_last;
    logic [DATA_W+1:0]  buf_out;
    logic [1:0]         occ;
    logic               pop;
    logic [1:0]         occ_eff;
    logic [1:0]         load;

    logic               word_vld;
    logic [15:0]        hdr_sync;
    logic [7:0]         hdr_type;
    logic [7:0]         hdr_len;
    logic               len_ok;

    assign word_vld = inflight_q;
    assign hdr_sync = fifo_rd_data[HDR_SYNC_HI:HDR_SYNC_LO];
    assign hdr_type = fifo_rd_data[HDR_TYPE_HI:HDR_TYPE_LO];
    assign hdr_len  = fifo_rd_data[HDR_LEN_HI:HDR_LEN_LO];
    assign len_ok   = (hdr_len != 8'd0) && ({24'd0, hdr_len} <= 32'(MAX_LEN));

    // A slot freed by this cycle's downstream handshake is credited at once so
    // a steady stream sustains one word per cycle without overflowing.
    assign pop        = m_valid && m_ready;
    assign occ_eff    = occ - {1'b0, pop};
    assign load       = occ_eff + {1'b0, inflight_q};
    assign fifo_rd_en = run_q && !fifo_rd_empty && (load < 2'd2);

    recv_skid_buf #(
        .W (DATA_W + 2)
    ) u_skid (
        .clk_i       (rd_clk),
        .rst_ni      (rd_rst_n),
        .in_valid_i  (push),
        .in_data_i   ({fifo_rd_data, push_first, push_last}),
        .out_valid_o (m_valid),
        .out_ready_i (m_ready),
        .out_data_o  (buf_out),
        .occ_o       (occ)
    );

    assign m_data     = buf_out[DATA_W+1:2];
    assign m_first    = buf_out[1];
    assign m_last     = buf_out[0];
    assign m_type     = type_q;
    assign frame_done = done_q;
    assign frame_err  = err_q;
    assign ok_cnt     = ok_cnt_q;
    assign err_cnt    = err_cnt_q;
    assign drop_cnt   = drop_cnt_q;

    // Frame FSM: next state, checksum accumulation and buffer push
    always_comb begin
        state_d    = state_q;
        sum_d      = sum_q;
        cnt_d      = cnt_q;
        type_d     = type_q;
        first_d    = first_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        ok_inc     = 1'b0;
        err_inc    = 1'b0;
        drop_inc   = 1'b0;
        push       = 1'b0;
        push_first = 1'b0;
        push_last  = 1'b0;
        case (state_q)
            ST_HUNT: begin
                if (word_vld) begin
                    if (hdr_sync == SYNC_WORD) begin
                        if (len_ok) begin
                            type_d  = hdr_type;
                            cnt_d   = hdr_len;
                            sum_d   = fifo_rd_data;
                            first_d = 1'b1;
                            state_d = ST_PAYLOAD;
                        end else begin
                            done_d  = 1'b1;
                            err_d   = 1'b1;
                            err_inc = 1'b1;
                        end
                    end else begin
                        drop_inc = 1'b1;
                    end
                end
            end
            ST_PAYLOAD: begin
                if (word_vld) begin
                    push       = 1'b1;
                    push_first = first_q;
                    push_last  = (cnt_q == 8'd1);
                    sum_d      = sum_q + fifo_rd_data;
                    cnt_d      = cnt_q - 8'd1;
                    first_d    = 1'b0;
                    if (cnt_q == 8'd1) begin
                        state_d = ST_TRAILER;
                    end
                end
            end
            ST_TRAILER: begin
                if (word_vld) begin
                    done_d  = 1'b1;
                    err_d   = (fifo_rd_data != sum_q);
                    ok_inc  = (fifo_rd_data == sum_q);
                    err_inc = (fifo_rd_data != sum_q);
                    state_d = ST_HUNT;
                end
            end
            default: begin
                state_d = ST_HUNT;
            end
        endcase
    end

    // FSM state, frame context and read-in-flight tracking
    always_ff @(posedge rd_clk or negedge rd_rst_n) begin
        if (!rd_rst_n) begin
            state_q    <= ST_HUNT;
            run_q      <= 1'b0;
            inflight_q <= 1'b0;
            sum_q      <= '0;
            cnt_q      <= '0;
            type_q     <= '0;
            first_q    <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            run_q      <= 1'b1;
            inflight_q <= fifo_rd_en;
            sum_q      <= sum_d;
            cnt_q      <= cnt_d;
            type_q     <= type_d;
            first_q    <= first_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    // Saturating statistics counters
    always_ff @(posedge rd_clk or negedge rd_rst_n) begin
        if (!rd_rst_n) begin
            ok_cnt_q   <= '0;
            err_cnt_q  <= '0;
            drop_cnt_q <= '0;
        end else begin
            if (ok_inc)   ok_cnt_q   <= sat_inc(ok_cnt_q);
            if (err_inc)  err_cnt_q  <= sat_inc(err_cnt_q);
            if (drop_inc) drop_cnt_q <= sat_inc(drop_cnt_q);
        end
    end

endmodule

// File: tb/tb_recv_frame_parser.sv
// Scoreboard bench for recv_frame_parser: a queue-based FIFO model feeds the
// DUT, stimulus pushes expected payload/done results, a monitor compares.
module tb_recv_frame_parser;

    typedef struct {
        logic [31:0] d;
        bit          pay;
    } fent_t;

    typedef struct {
        logic [31:0] d;
        bit          f;
        bit          l;
    } oent_t;

    typedef struct {
        bit          err;
        bit          chk_type;
        logic [7:0]  t;
    } dent_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        fifo_rd_en;
    logic [31:0] fifo_rd_data = '0;
    logic        fifo_rd_empty = 1'b1;
    logic        m_valid;
    logic        m_ready = 1'b1;
    logic [31:0] m_data;
    logic        m_first;
    logic        m_last;
    logic [7:0]  m_type;
    logic        frame_done;
    logic        frame_err;
    logic [15:0] ok_cnt;
    logic [15:0] err_cnt;
    logic [15:0] drop_cnt;

    fent_t fq[$];
    oent_t eq[$];
    dent_t dq[$];

    int checks = 0;
    int fails  = 0;
    int pending = 0;
    int cyc = 0;
    int first_rd = -1;
    int first_vld = -1;
    bit rand_mode = 1'b0;
    bit gap = 1'b0;

    always #5 clk = ~clk;

    recv_frame_parser #(
        .DATA_W    (32),
        .MAX_LEN   (255),
        .SYNC_WORD (16'hA55A)
    ) dut (
        .rd_clk        (clk),
        .rd_rst_n      (rst_n),
        .fifo_rd_en    (fifo_rd_en),
        .fifo_rd_data  (fifo_rd_data),
        .fifo_rd_empty (fifo_rd_empty),
        .m_valid       (m_valid),
        .m_ready       (m_ready),
        .m_data        (m_data),
        .m_first       (m_first),
        .m_last        (m_last),
        .m_type        (m_type),
        .frame_done    (frame_done),
        .frame_err     (frame_err),
        .ok_cnt        (ok_cnt),
        .err_cnt       (err_cnt),
        .drop_cnt      (drop_cnt)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // FIFO model with one-cycle read latency; tracks payload words not yet delivered
    always @(posedge clk) begin
        if (!rst_n) begin
            pending = 0;
        end else begin
            if (m_valid && m_ready) pending = pending - 1;
            if (fifo_rd_en) begin
                if (fq.size() == 0) begin
                    chk("fifo_underflow", 32'd1, 32'd0);
                end else begin
                    fent_t e;
                    e = fq.pop_front();
                    fifo_rd_data <= e.d;
                    if (e.pay) pending = pending + 1;
                end
            end
        end
    end

    // Input drivers, updated just after the active edge
    always @(posedge clk) begin
        #1;
        m_ready = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
        gap = rand_mode ? ($urandom_range(0, 3) == 0) : 1'b0;
        fifo_rd_empty = gap || (fq.size() == 0);
    end

    // Monitor: scoreboard compare, stall stability and read-gate bound
    logic        prev_stall = 1'b0;
    logic [31:0] prev_data;
    logic        prev_first, prev_last;
    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (fifo_rd_en && first_rd < 0) first_rd = cyc;
            if (m_valid && first_vld < 0) first_vld = cyc;
            if (prev_stall) begin
                chk("stall_valid", {31'd0, m_valid}, 32'd1);
                chk("stall_data", m_data, prev_data);
                chk("stall_marks", {30'd0, m_first, m_last}, {30'd0, prev_first, prev_last});
            end
            if (m_valid && m_ready) begin
                if (eq.size() == 0) begin
                    chk("unexpected_word", m_data, 32'hxxxx_xxxx);
                end else begin
                    oent_t o;
                    o = eq.pop_front();
                    chk("m_data", m_data, o.d);
                    chk("m_first_last", {30'd0, m_first, m_last}, {30'd0, o.f, o.l});
                end
            end
            if (frame_done) begin
                if (dq.size() == 0) begin
                    chk("unexpected_done", 32'd1, 32'd0);
                end else begin
                    dent_t de;
                    de = dq.pop_front();
                    chk("frame_err", {31'd0, frame_err}, {31'd0, de.err});
                    if (de.chk_type) chk("m_type", {24'd0, m_type}, {24'd0, de.t});
                end
            end
            if (fifo_rd_en) begin
                chk("rd_gate", (pending - ((m_valid && m_ready) ? 1 : 0)) < 2 ? 32'd1 : 32'd0, 32'd1);
            end
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
            prev_first = m_first;
            prev_last  = m_last;
        end
    end

    // Payload word i of a frame is base*(i+1); trailer is the 32-bit sum
    task automatic send_frame(input logic [7:0] t, input int n, input logic [31:0] base,
                              input bit corrupt);
        logic [31:0] hdr;
        logic [31:0] sum;
        logic [31:0] w;
        hdr = {16'hA55A, t, 8'(n)};
        sum = hdr;
        fq.push_back('{d: hdr, pay: 1'b0});
        for (int i = 0; i < n; i++) begin
            w = base * 32'(i + 1);
            sum = sum + w;
            fq.push_back('{d: w, pay: 1'b1});
            eq.push_back('{d: w, f: (i == 0), l: (i == n - 1)});
        end
        fq.push_back('{d: (corrupt ? 32'h0000_0000 : sum), pay: 1'b0});
        dq.push_back('{err: corrupt, chk_type: 1'b1, t: t});
    endtask

    task automatic wait_idle(input string nm);
        int n;
        n = 0;
        while ((fq.size() != 0 || eq.size() != 0 || dq.size() != 0 || m_valid) && n < 6000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 6000) chk({nm, "_timeout"}, 32'd1, 32'd0);
        repeat (4) @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        // Frame {A55A_0103, 11, 22, 33, A55A_0169} is loaded while in reset
        send_frame(8'h01, 3, 32'h11, 1'b0);
        repeat (3) @(negedge clk);
        chk("rst_rd_en", {31'd0, fifo_rd_en}, 32'd0);
        chk("rst_m_valid", {31'd0, m_valid}, 32'd0);
        chk("rst_m_data", m_data, 32'd0);
        chk("rst_first_last", {30'd0, m_first, m_last}, 32'd0);
        chk("rst_m_type", {24'd0, m_type}, 32'd0);
        chk("rst_done_err", {30'd0, frame_done, frame_err}, 32'd0);
        chk("rst_ok_cnt", {16'd0, ok_cnt}, 32'd0);
        chk("rst_err_cnt", {16'd0, err_cnt}, 32'd0);
        chk("rst_drop_cnt", {16'd0, drop_cnt}, 32'd0);
        rst_n = 1'b1;

        wait_idle("t1");
        chk("t1_latency", 32'(first_vld - first_rd), 32'd3);
        chk("t1_ok_cnt", {16'd0, ok_cnt}, 32'd1);
        chk("t1_err_cnt", {16'd0, err_cnt}, 32'd0);

        // Same frame, zero trailer
        send_frame(8'h01, 3, 32'h11, 1'b1);
        wait_idle("t2");
        chk("t2_err_cnt", {16'd0, err_cnt}, 32'd1);
        chk("t2_ok_cnt", {16'd0, ok_cnt}, 32'd1);

        // Junk words ahead of a good frame
        fq.push_back('{d: 32'hDEAD_BEEF, pay: 1'b0});
        fq.push_back('{d: 32'h1234_5678, pay: 1'b0});
        send_frame(8'h02, 2, 32'h1000_0001, 1'b0);
        wait_idle("t3");
        chk("t3_drop_cnt", {16'd0, drop_cnt}, 32'd2);
        chk("t3_ok_cnt", {16'd0, ok_cnt}, 32'd2);

        // Zero-length header, then a good frame parsed from HUNT
        fq.push_back('{d: 32'hA55A_0700, pay: 1'b0});
        dq.push_back('{err: 1'b1, chk_type: 1'b0, t: 8'h00});
        send_frame(8'h03, 1, 32'h7, 1'b0);
        wait_idle("t4");
        chk("t4_err_cnt", {16'd0, err_cnt}, 32'd2);
        chk("t4_ok_cnt", {16'd0, ok_cnt}, 32'd3);
        chk("t4_drop_cnt", {16'd0, drop_cnt}, 32'd2);

        // Maximum-length frame under random backpressure and FIFO gaps
        rand_mode = 1'b1;
        send_frame(8'h05, 255, 32'h0100_0007, 1'b0);
        wait_idle("t5");
        rand_mode = 1'b0;
        repeat (2) @(negedge clk);
        chk("t5_ok_cnt", {16'd0, ok_cnt}, 32'd4);
        chk("t5_err_cnt", {16'd0, err_cnt}, 32'd2);

        // Partial frame (4 of 10 words), reset, then a fresh frame
        fq.push_back('{d: 32'hA55A_090A, pay: 1'b0});
        for (int i = 0; i < 4; i++) begin
            fq.push_back('{d: 32'h0BAD_0000 + 32'(i), pay: 1'b1});
            eq.push_back('{d: 32'h0BAD_0000 + 32'(i), f: (i == 0), l: 1'b0});
        end
        wait_idle("t6a");
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("t6_rst_ok_cnt", {16'd0, ok_cnt}, 32'd0);
        chk("t6_rst_err_cnt", {16'd0, err_cnt}, 32'd0);
        chk("t6_rst_valid", {31'd0, m_valid}, 32'd0);
        rst_n = 1'b1;
        send_frame(8'h06, 2, 32'h55, 1'b0);
        wait_idle("t6b");
        chk("t6_ok_cnt", {16'd0, ok_cnt}, 32'd1);
        chk("t6_err_cnt", {16'd0, err_cnt}, 32'd0);
        chk("t6_drop_cnt", {16'd0, drop_cnt}, 32'd0);
        chk("t6_type", {24'd0, m_type}, 32'h06);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    // Global bound on run time
    initial begin
        #500000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
